// File: rtl/regset_pkg.sv
// Shared definitions for the register-set operation sequencer.
//   - Default widths and register count for the 6x4-bit register set.
//   - Opcode constants OP_ADD..OP_NOP.
//   - Sequencer state enum (IDLE, READ, EXEC, WRITE).
//   - Opcode classification helpers used for index legality checks.
package regset_pkg;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_NUM_REGS = 6;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Every opcode except NOP produces a register write.
  function automatic logic op_writes(input logic [2:0] op);
    return op != OP_NOP;
  endfunction

  // ADD..MOV consume operand A.
  function automatic logic op_reads_a(input logic [2:0] op);
    return op <= OP_MOV;
  endfunction

  // ADD..XOR consume operand B.
  function automatic logic op_reads_b(input logic [2:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/regset_alu.sv
// Combinational ALU for the register-set sequencer.
// Ports:
//   op       in  3       opcode
//   a, b     in  DATA_W  operands
//   imm      in  DATA_W  immediate (LDI)
//   result   out DATA_W  result truncated to DATA_W
//   carry    out 1       carry-out (ADD), borrow (SUB), 0 otherwise
//   flag_upd out 1       opcode updates the carry/zero flags
module regset_alu
  import regset_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              flag_upd
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    flag_upd = 1'b0;
    case (op)
      OP_ADD: begin result = sum[DATA_W-1:0];  carry = sum[DATA_W]; flag_upd = 1'b1; end
      // Borrow out of the extended subtraction is exactly a < b.
      OP_SUB: begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; flag_upd = 1'b1; end
      OP_AND: begin result = a & b; flag_upd = 1'b1; end
      OP_OR:  begin result = a | b; flag_upd = 1'b1; end
      OP_XOR: begin result = a ^ b; flag_upd = 1'b1; end
      OP_MOV: result = a;
      OP_LDI: result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regset_op_sequencer.sv
// Initiator side of the 6x4-bit register-set interface. Accepts one ALU
// instruction per handshake, reads operands through RA/RB, computes the
// result and writes it back through WR/WRD/Reg_EN.
// Ports:
//   clock, reset           clock (rising edge), asynchronous active-high reset
//   instr_valid/ready      instruction handshake; ready is registered
//   instr_op/rd/ra/rb/imm  instruction fields
//   RA, RB  out            register-file read addresses
//   A, B    in             register-file read data (combinational from RA/RB)
//   WR, WRD, Reg_EN out    write address, data, one-cycle write enable
//   done, err       out    retire pulse, illegal-index pulse (with done)
//   flag_c, flag_z  out    carry/borrow and zero flags
module regset_op_sequencer
  import regset_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] RA,
  output logic [ADDR_W-1:0] RB,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [ADDR_W-1:0] WR,
  output logic [DATA_W-1:0] WRD,
  output logic              Reg_EN,
  output logic              done,
  output logic              err,
  output logic              flag_c,
  output logic              flag_z
);

  state_t            state_q, state_d;
  logic              accept;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_upd;
  logic              illegal, wen;

  function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
    return {1'b0, idx} < (ADDR_W+1)'(NUM_REGS);
  endfunction

  regset_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .imm     (imm_q),
    .result  (alu_res),
    .carry   (alu_c),
    .flag_upd(alu_upd)
  );

  // RA/RB double as the latched source indices of the current instruction.
  assign illegal = (op_writes(op_q)  && !idx_ok(rd_q)) ||
                   (op_reads_a(op_q) && !idx_ok(RA))   ||
                   (op_reads_b(op_q) && !idx_ok(RB));
  assign wen     = op_writes(op_q) && !illegal;
  assign accept  = (state_q == IDLE) && instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Instruction fields and operands: only meaningful once an instruction is in flight.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q  <= instr_op;
      rd_q  <= instr_rd;
      imm_q <= instr_imm;
    end
    if (state_q == READ) begin
      a_q <= A;
      b_q <= B;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_ready <= 1'b0;
      RA          <= '0;
      RB          <= '0;
      WR          <= '0;
      WRD         <= '0;
      Reg_EN      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
    end else begin
      instr_ready <= (state_d == IDLE);
      Reg_EN      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      // Accept edge: drive read addresses for the READ cycle
      if (accept) begin
        RA <= instr_ra;
        RB <= instr_rb;
      end
      // EXEC -> WRITE edge: result, flags and retire pulses
      if (state_q == EXEC) begin
        done   <= 1'b1;
        err    <= illegal;
        Reg_EN <= wen;
        if (wen) begin
          WR  <= rd_q;
          WRD <= alu_res;
        end
        if (alu_upd && !illegal) begin
          flag_c <= alu_c;
          flag_z <= (alu_res == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_regset_op_sequencer.sv
// Bench for regset_op_sequencer paired with a 6x4-bit register file model.
module tb_regset_op_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = 3'd0, instr_rd = 3'd0, instr_ra = 3'd0, instr_rb = 3'd0;
  logic [3:0] instr_imm = 4'd0;
  logic [2:0] RA, RB, WR;
  logic [3:0] A, B, WRD;
  logic       Reg_EN, done, err, flag_c, flag_z;

  logic [3:0] rf [0:5] = '{default: 4'h0};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct packed {
    logic       wen;
    logic [2:0] wr;
    logic [3:0] wrd;
    logic       e, c, z;
    int         acc;
  } exp_t;

  exp_t q[$];

  regset_op_sequencer dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
    .instr_rb(instr_rb), .instr_imm(instr_imm),
    .RA(RA), .RB(RB), .A(A), .B(B),
    .WR(WR), .WRD(WRD), .Reg_EN(Reg_EN),
    .done(done), .err(err), .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  // regset6 model: combinational reads, write on rising edge when enabled.
  always_comb begin
    A = (RA < 3'd6) ? rf[RA] : 4'h0;
    B = (RB < 3'd6) ? rf[RB] : 4'h0;
  end
  always @(posedge clock) if (Reg_EN && WR < 3'd6) rf[WR] <= WRD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: each done pulse retires the oldest expected instruction.
  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t x;
          x = q.pop_front();
          // READ, EXEC, then WRITE: done is seen two edges after the accept edge.
          chk("latency", cyc, x.acc + 2);
          chk("reg_en", Reg_EN, x.wen);
          chk("err", err, x.e);
          chk("flag_c", flag_c, x.c);
          chk("flag_z", flag_z, x.z);
          if (x.wen) begin
            chk("wr", WR, x.wr);
            chk("wrd", WRD, x.wrd);
          end
        end
      end else if (Reg_EN) chk("reg_en_without_done", 1, 0);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [3:0] imm, input bit push,
                       input bit wen, input logic [3:0] wrd, input bit e, input bit c,
                       input bit z, input bit gap);
    bit ok;
    ok = 1'b0;
    @(negedge clock);
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      if (gap) chk("issue_gap", (cyc + 1) - last_acc, 4);
      last_acc = cyc + 1;
      if (push) q.push_back('{wen: wen, wr: rd, wrd: wrd, e: e, c: c, z: z, acc: cyc + 1});
      @(posedge clock);
    end
  endtask

  task automatic drop();
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clock);
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    chk("reset_outputs", {instr_ready, RA, RB, WR, WRD, Reg_EN, done, err, flag_c, flag_z}, 0);
    reset = 1'b0;
    chk("ready_before_edge", instr_ready, 0);
    @(negedge clock);
    chk("ready_after_reset", instr_ready, 1);

    //     op      rd    ra    rb    imm    push wen wrd   e  c  z  gap
    issue(3'b110, 3'd1, 3'd0, 3'd0, 4'h5, 1, 1, 4'h5, 0, 0, 0, 0); drop();
    issue(3'b110, 3'd1, 3'd0, 3'd0, 4'h7, 1, 1, 4'h7, 0, 0, 0, 0); drop();
    issue(3'b110, 3'd2, 3'd0, 3'd0, 4'hA, 1, 1, 4'hA, 0, 0, 0, 0); drop();
    issue(3'b000, 3'd3, 3'd1, 3'd2, 4'h0, 1, 1, 4'h1, 0, 1, 0, 0); drop();
    issue(3'b001, 3'd4, 3'd1, 3'd1, 4'h0, 1, 1, 4'h0, 0, 0, 1, 0); drop();
    issue(3'b001, 3'd5, 3'd1, 3'd2, 4'h0, 1, 1, 4'hD, 0, 1, 0, 0); drop();
    issue(3'b000, 3'd6, 3'd1, 3'd2, 4'h0, 1, 0, 4'h0, 1, 1, 0, 0); drop();
    issue(3'b101, 3'd0, 3'd7, 3'd0, 4'h0, 1, 0, 4'h0, 1, 1, 0, 0); drop();
    issue(3'b010, 3'd0, 3'd1, 3'd2, 4'h0, 1, 1, 4'h2, 0, 0, 0, 0); drop();
    issue(3'b011, 3'd0, 3'd1, 3'd2, 4'h0, 1, 1, 4'hF, 0, 0, 0, 0); drop();
    issue(3'b100, 3'd4, 3'd1, 3'd2, 4'h0, 1, 1, 4'hD, 0, 0, 0, 0); drop();
    issue(3'b101, 3'd3, 3'd2, 3'd0, 4'h0, 1, 1, 4'hA, 0, 0, 0, 0); drop();
    issue(3'b111, 3'd7, 3'd7, 3'd7, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0); drop();
    issue(3'b110, 3'd7, 3'd0, 3'd0, 4'h3, 1, 0, 4'h0, 1, 0, 0, 0); drop();
    drain();
    chk("rf_r1", rf[1], 4'h7);
    chk("rf_r3", rf[3], 4'hA);
    chk("rf_r4", rf[4], 4'hD);
    chk("rf_r0", rf[0], 4'hF);

    // instr_valid held high: one accept every 4 cycles
    issue(3'b110, 3'd0, 3'd0, 3'd0, 4'h3, 1, 1, 4'h3, 0, 0, 0, 0);
    issue(3'b110, 3'd1, 3'd0, 3'd0, 4'hC, 1, 1, 4'hC, 0, 0, 0, 1);
    issue(3'b000, 3'd2, 3'd0, 3'd1, 4'h0, 1, 1, 4'hF, 0, 0, 0, 1);
    drop();
    drain();
    chk("rf_r2_stream", rf[2], 4'hF);

    // Reset during EXEC of ADD rd=5: instruction is lost
    issue(3'b000, 3'd5, 3'd1, 3'd2, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    instr_valid = 1'b0;
    #1 chk("midreset_outputs", {instr_ready, RA, RB, WR, WRD, Reg_EN, done, err, flag_c, flag_z}, 0);
    repeat (3) @(negedge clock);
    chk("midreset_r5", rf[5], 4'hD);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_midreset", instr_ready, 1);
    repeat (3) @(negedge clock);
    chk("r5_after_abort", rf[5], 4'hD);
    issue(3'b110, 3'd5, 3'd0, 3'd0, 4'h6, 1, 1, 4'h6, 0, 0, 0, 0); drop();
    drain();
    chk("rf_r5_recover", rf[5], 4'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
